note_history_scroller: RTL

- Producer for the eight-digit note display: captures each new note press and keeps the last six notes as 3-bit note codes on SEG1–SEG6.
- After a period with no new note, the history scrolls off the display one blank at a time until it is empty.
- Sits between the keyboard/note-mapping logic and the seven-segment controller; its six outputs drive that controller's scrolled-note inputs directly.

---
 rtl/piano_display_pkg.sv | 26 ++
 rtl/note_event_detector.sv | 38 +++
 rtl/note_history_scroller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/piano_display_pkg.sv
// Shared definitions for the piano note display path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package piano_display_pkg;

    // Note codes as produced by the keyboard/note-mapping logic
    localparam logic [2:0] NOTE_BLANK = 3'd0;
    localparam logic [2:0] NOTE_DO    = 3'd1;
    localparam logic [2:0] NOTE_RE    = 3'd2;
    localparam logic [2:0] NOTE_MI    = 3'd3;
    localparam logic [2:0] NOTE_FA    = 3'd4;
    localparam logic [2:0] NOTE_SOL   = 3'd5;
    localparam logic [2:0] NOTE_LA    = 3'd6;
    localparam logic [2:0] NOTE_TI    = 3'd7;

    // Number of history slots shown on the display
    localparam int HISTORY_DEPTH = 6;

    // Scroller state encoding
    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_HOLD       = 2'd1,
        ST_SCROLL_OUT = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/note_event_detector.sv
// Turns a held key into a single-cycle note event (new press or note change).
// Latency: combinational event against last cycle's registered key state.
// Backpressure: none; clear suppresses the event and marks a held key as consumed.
module note_event_detector
    import piano_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_note_id,
    input  logic       i_note_vld,
    input  logic       i_clear,
    output logic       o_event,
    output logic [2:0] o_event_note
);

    logic       w_active;
    logic       r_prev_active;
    logic [2:0] r_prev_id;

    assign w_active = i_note_vld && (i_note_id != NOTE_BLANK);

    // Track last cycle's key; during clear the current key is still recorded so a
    // key held across the clear does not produce an event until re-pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_active <= 1'b0;
            r_prev_id     <= NOTE_BLANK;
        end else begin
            r_prev_active <= w_active;
            r_prev_id     <= i_note_id;
        end
    end

    assign o_event      = w_active && !i_clear &&
                          (!r_prev_active || (i_note_id != r_prev_id));
    assign o_event_note = i_note_id;

endmodule

// File: rtl/note_history_scroller.sv
// Keeps the last six note presses for the display and scrolls them out after idling.
// Latency: one cycle from a sampled note event or step tick to the outputs.
// Backpressure: none; clear beats a note event, which beats a step tick/idle timeout.
module note_history_scroller
    import piano_display_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 150_000_000,
    parameter int unsigned STEP_CYCLES = 25_000_000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] note_id_in,
    input  logic       note_valid_in,
    input  logic       clear_in,
    output logic [2:0] scrolled_note_seg1_out,
    output logic [2:0] scrolled_note_seg2_out,
    output logic [2:0] scrolled_note_seg3_out,
    output logic [2:0] scrolled_note_seg4_out,
    output logic [2:0] scrolled_note_seg5_out,
    output logic [2:0] scrolled_note_seg6_out,
    output logic [2:0] note_count_out,
    output logic       scrolling_out
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES);
    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    // Slot 0 is the newest note (seg1), slot HISTORY_DEPTH-1 the oldest (seg6)
    logic [HISTORY_DEPTH-1:0][2:0] r_slots;
    logic [2:0]                    r_count;
    logic [IDLE_W-1:0]             r_idle_cnt;
    logic [STEP_W-1:0]             r_step_cnt;
    scroll_state_t                 r_state;
    logic                          r_scrolling;

    logic       w_event;
    logic [2:0] w_event_note;
    logic       w_oldest_nz;
    logic [2:0] w_push_count;
    logic [2:0] w_shift_count;

    note_event_detector u_detector (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_note_id    (note_id_in),
        .i_note_vld   (note_valid_in),
        .i_clear      (clear_in),
        .o_event      (w_event),
        .o_event_note (w_event_note)
    );

    // Slots need not be contiguous, so the count only drops when a real note falls off seg6
    assign w_oldest_nz   = (r_slots[HISTORY_DEPTH-1] != NOTE_BLANK);
    assign w_push_count  = r_count + 3'd1 - {2'b00, w_oldest_nz};
    assign w_shift_count = r_count - {2'b00, w_oldest_nz};

    // History FSM: push on events, idle timeout into scroll-out, blank shifts on step ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots     <= '0;
            r_count     <= '0;
            r_idle_cnt  <= '0;
            r_step_cnt  <= '0;
            r_state     <= ST_EMPTY;
            r_scrolling <= 1'b0;
        end else if (clear_in) begin
            r_slots     <= '0;
            r_count     <= '0;
            r_idle_cnt  <= '0;
            r_step_cnt  <= '0;
            r_state     <= ST_EMPTY;
            r_scrolling <= 1'b0;
        end else if (w_event) begin
            // A coincident step tick is dropped: the push restarts the idle period
            r_slots     <= {r_slots[HISTORY_DEPTH-2:0], w_event_note};
            r_count     <= w_push_count;
            r_idle_cnt  <= '0;
            r_step_cnt  <= '0;
            r_state     <= ST_HOLD;
            r_scrolling <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_idle_cnt == IDLE_LAST) begin
                        r_idle_cnt  <= '0;
                        r_step_cnt  <= '0;
                        r_state     <= ST_SCROLL_OUT;
                        r_scrolling <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                    end
                end
                ST_SCROLL_OUT: begin
                    if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                        r_slots    <= {r_slots[HISTORY_DEPTH-2:0], NOTE_BLANK};
                        r_count    <= w_shift_count;
                        if (w_shift_count == 3'd0) begin
                            r_state     <= ST_EMPTY;
                            r_scrolling <= 1'b0;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + STEP_W'(1);
                    end
                end
                default: begin
                    r_idle_cnt <= '0;
                    r_step_cnt <= '0;
                end
            endcase
        end
    end

    assign scrolled_note_seg1_out = r_slots[0];
    assign scrolled_note_seg2_out = r_slots[1];
    assign scrolled_note_seg3_out = r_slots[2];
    assign scrolled_note_seg4_out = r_slots[3];
    assign scrolled_note_seg5_out = r_slots[4];
    assign scrolled_note_seg6_out = r_slots[5];
    assign note_count_out         = r_count;
    assign scrolling_out          = r_scrolling;

endmodule
